// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam int DEF_LINES  = 16;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;
  localparam int OFFSET_W   = $clog2(DEF_LINE_W / 8);
  localparam int INDEX_W    = $clog2(DEF_LINES);
  localparam int TAG_W      = DEF_ADDR_W - INDEX_W - OFFSET_W;

  // Rebuild a line-aligned byte address from its tag and index fields.
  function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                            input logic [31:0] index,
                                            input int          index_w,
                                            input int          offset_w);
    return (tag << (index_w + offset_w)) | (index << offset_w);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: asynchronous read, synchronous write,
// flags cleared asynchronously by reset.
module dcache_array #(
  parameter int LINES  = 16,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 23,
  parameter int IDX_W  = $clog2(LINES),
  parameter int WSEL_W = $clog2(LINE_W / 32)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic              fill_we,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);

  logic [LINES-1:0]  valid_r;
  logic [LINES-1:0]  dirty_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [LINE_W-1:0] data_r [LINES];

  assign rd_valid = valid_r[idx];
  assign rd_dirty = dirty_r[idx];
  assign rd_tag   = tag_r[idx];
  assign rd_line  = data_r[idx];

  // Line flags: a refill makes a line valid and clean, a store hit makes it dirty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_we) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_r[idx] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the flags say whether they mean anything
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_r[idx]  <= fill_tag;
      data_r[idx] <= fill_line;
    end else if (word_we) begin
      data_r[idx][word_sel*32 +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller: hit logic
// and the IDLE/WRITEBACK/ALLOCATE miss FSM in front of a line-wide memory port.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(LINES);
  localparam int WSEL_W = $clog2(LINE_W / 32);
  localparam int TAG_W_L = ADDR_W - IDX_W - OFF_W;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [TAG_W_L-1:0]  lat_tag_r;
  logic [IDX_W-1:0]    lat_idx_r;

  logic [TAG_W_L-1:0]  cpu_tag_s;
  logic [IDX_W-1:0]    cpu_idx_s;
  logic [WSEL_W-1:0]   cpu_wsel_s;
  logic [IDX_W-1:0]    arr_idx_s;
  logic                rd_valid_s;
  logic                rd_dirty_s;
  logic [TAG_W_L-1:0]  rd_tag_s;
  logic [LINE_W-1:0]   rd_line_s;
  logic                req_s;
  logic                hit_s;
  logic                miss_s;
  logic                word_we_s;
  logic                fill_we_s;
  logic                unused_s;

  assign cpu_tag_s  = cpu_addr_i[ADDR_W-1 -: TAG_W_L];
  assign cpu_idx_s  = cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_wsel_s = cpu_addr_i[2 +: WSEL_W];
  assign unused_s   = ^cpu_addr_i[1:0];

  // During a miss the array is steered by the latched address, not the CPU bus
  assign arr_idx_s = (state_r == IDLE) ? cpu_idx_s : lat_idx_r;
  assign req_s     = cpu_req_i & ~rst_i;
  assign hit_s     = req_s & (state_r == IDLE) & rd_valid_s & (rd_tag_s == cpu_tag_s);
  assign miss_s    = req_s & (state_r == IDLE) & ~hit_s;

  dcache_array #(
    .LINES  (LINES),
    .LINE_W (LINE_W),
    .TAG_W  (TAG_W_L),
    .IDX_W  (IDX_W),
    .WSEL_W (WSEL_W)
  ) u_array (
    .clk       (clk_i),
    .rst       (rst_i),
    .idx       (arr_idx_s),
    .rd_valid  (rd_valid_s),
    .rd_dirty  (rd_dirty_s),
    .rd_tag    (rd_tag_s),
    .rd_line   (rd_line_s),
    .word_we   (word_we_s),
    .word_sel  (cpu_wsel_s),
    .word_data (cpu_data_i),
    .fill_we   (fill_we_s),
    .fill_tag  (lat_tag_r),
    .fill_line (mem_data_i)
  );

  // State register plus the miss address captured when the miss is first seen
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      lat_tag_r <= '0;
      lat_idx_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (miss_s) begin
        lat_tag_r <= cpu_tag_s;
        lat_idx_r <= cpu_idx_s;
      end else begin
        lat_tag_r <= lat_tag_r;
        lat_idx_r <= lat_idx_r;
      end
    end
  end

  // Next-state logic; acks outside a transaction are ignored
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_nxt_s = (rd_valid_s & rd_dirty_s) ? WRITEBACK : ALLOCATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_nxt_s = ALLOCATE;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ALLOCATE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs: CPU data/stall on the hit path, line transactions while missing
  always_comb begin
    cpu_data_o  = 32'd0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    word_we_s   = 1'b0;
    fill_we_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cpu_stall_o = miss_s;
        word_we_s   = hit_s & cpu_we_i;
        if (hit_s & ~cpu_we_i) begin
          cpu_data_o = rd_line_s[cpu_wsel_s*32 +: 32];
        end else begin
          cpu_data_o = 32'd0;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(32'(rd_tag_s), 32'(lat_idx_r), IDX_W, OFF_W);
        mem_data_o  = rd_line_s;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = line_addr(32'(lat_tag_r), 32'(lat_idx_r), IDX_W, OFF_W);
        fill_we_s   = mem_ack_i;
      end
      default: begin
        cpu_stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a latency-programmable line memory responder.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  int           wb_lat = 0;
  int           rd_lat = 0;
  logic [255:0] fill_line = '0;
  int           wb_count = 0;
  int           rd_count = 0;
  int           req_rises = 0;
  logic [31:0]  last_wb_addr = 32'd0;
  logic [255:0] last_wb_line = '0;
  logic [31:0]  last_rd_addr = 32'd0;
  int           spur_req = 0;

  int           stalls;
  logic [31:0]  rdata;

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Memory responder: acks `lat` cycles after the request is first seen
  initial begin
    int  wait_cnt;
    int  lat;
    int  spur_done;
    logic prev_req;
    wait_cnt   = 0;
    spur_done  = 0;
    prev_req   = 1'b0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (mem_req_o && !prev_req) req_rises++;
      prev_req = mem_req_o;
      if (mem_req_o) begin
        lat = mem_we_o ? wb_lat : rd_lat;
        if (wait_cnt >= lat) begin
          mem_ack_i = 1'b1;
          wait_cnt  = 0;
          if (mem_we_o) begin
            wb_count++;
            last_wb_addr = mem_addr_o;
            last_wb_line = mem_data_o;
          end else begin
            rd_count++;
            last_rd_addr = mem_addr_o;
            mem_data_i   = fill_line;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur_req != spur_done) begin
          spur_done  = spur_req;
          mem_ack_i  = 1'b1;
          mem_data_i = {8{32'hBAD0_BAD0}};
        end
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int n, output logic [31:0] rd);
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    #1;
    n = 0;
    while (cpu_stall_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_i);
      #1;
    end
    if (n >= 200) check_val("stall_timeout", 32'(n), 32'd0);
    rd = cpu_data_o;
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'd0;
    cpu_data_i = 32'd0;
    #2;
    check_val("rst_stall", 32'(cpu_stall_o), 32'd0);
    check_val("rst_req", 32'(mem_req_o), 32'd0);
    check_val("rst_we", 32'(mem_we_o), 32'd0);
    check_val("rst_addr", mem_addr_o, 32'd0);
    check_val("rst_data", cpu_data_o, 32'd0);
    cpu_req_i = 1'b1;
    #1;
    check_val("rst_stall_req", 32'(cpu_stall_o), 32'd0);
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Cold read miss, refill after 10 cycles
    rd_lat = 10; fill_line = make_line(32'h1234_5678);
    access(1'b0, 32'h0000_0000, 32'd0, stalls, rdata);
    check_val("cold_stall", 32'(stalls), 32'd12);
    check_val("cold_data", rdata, 32'h1234_5678);
    check_val("cold_rd_addr", last_rd_addr, 32'h0000_0000);
    check_val("cold_rd_cnt", 32'(rd_count), 32'd1);

    // Store hit then loads from the same line
    access(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, stalls, rdata);
    check_val("st_hit_stall", 32'(stalls), 32'd0);
    check_val("st_hit_data0", rdata, 32'd0);
    access(1'b0, 32'h0000_0004, 32'd0, stalls, rdata);
    check_val("ld_hit_stall", 32'(stalls), 32'd0);
    check_val("ld_hit_data", rdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0008, 32'd0, stalls, rdata);
    check_val("ld_w2_data", rdata, 32'h1234_567A);
    check_val("no_wb_yet", 32'(wb_count), 32'd0);

    // Dirty eviction: write-back 3 cycles, refill 4 cycles
    wb_lat = 3; rd_lat = 4; fill_line = make_line(32'hB000_0000);
    access(1'b0, 32'h0000_0200, 32'd0, stalls, rdata);
    check_val("evict_stall", 32'(stalls), 32'd10);
    check_val("evict_data", rdata, 32'hB000_0000);
    check_val("evict_wb_cnt", 32'(wb_count), 32'd1);
    check_val("evict_wb_addr", last_wb_addr, 32'h0000_0000);
    check_val("evict_wb_w0", last_wb_line[31:0], 32'h1234_5678);
    check_val("evict_wb_w1", last_wb_line[63:32], 32'hDEAD_BEEF);
    check_val("evict_wb_w2", last_wb_line[95:64], 32'h1234_567A);
    check_val("evict_rd_addr", last_rd_addr, 32'h0000_0200);
    check_val("evict_req_rises", 32'(req_rises), 32'd2);

    // Write miss: refill first, store lands afterwards, no direct memory write
    rd_lat = 2; fill_line = make_line(32'hC000_0000);
    access(1'b1, 32'h0000_0124, 32'hCAFE_F00D, stalls, rdata);
    check_val("wmiss_stall", 32'(stalls), 32'd4);
    check_val("wmiss_wb_cnt", 32'(wb_count), 32'd1);
    check_val("wmiss_rd_addr", last_rd_addr, 32'h0000_0120);
    access(1'b0, 32'h0000_0124, 32'd0, stalls, rdata);
    check_val("wmiss_w1", rdata, 32'hCAFE_F00D);
    access(1'b0, 32'h0000_0120, 32'd0, stalls, rdata);
    check_val("wmiss_w0", rdata, 32'hC000_0000);
    wb_lat = 0; rd_lat = 1; fill_line = make_line(32'hF000_0000);
    access(1'b0, 32'h0000_0320, 32'd0, stalls, rdata);
    check_val("wmiss_evict_stall", 32'(stalls), 32'd4);
    check_val("wmiss_evict_wb_addr", last_wb_addr, 32'h0000_0120);
    check_val("wmiss_evict_wb_w1", last_wb_line[63:32], 32'hCAFE_F00D);
    check_val("wmiss_evict_data", rdata, 32'hF000_0000);

    // Reset in the middle of a 10-cycle refill
    rd_lat = 10; fill_line = make_line(32'h5555_0000);
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040;
    repeat (6) @(negedge clk_i);
    #1;
    check_val("mid_req", 32'(mem_req_o), 32'd1);
    check_val("mid_addr", mem_addr_o, 32'h0000_0040);
    rst_i = 1'b1;
    #1;
    check_val("mid_rst_req", 32'(mem_req_o), 32'd0);
    check_val("mid_rst_stall", 32'(cpu_stall_o), 32'd0);
    check_val("mid_rst_addr", mem_addr_o, 32'd0);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_val("mid_rd_cnt", 32'(rd_count), 32'd4);
    rd_lat = 1; fill_line = make_line(32'hD000_0000);
    access(1'b0, 32'h0000_0040, 32'd0, stalls, rdata);
    check_val("post_rst_stall", 32'(stalls), 32'd3);
    check_val("post_rst_data", rdata, 32'hD000_0000);
    wb_lat = 0; rd_lat = 0; fill_line = make_line(32'hE000_0000);
    access(1'b0, 32'h0000_0200, 32'd0, stalls, rdata);
    check_val("post_rst_miss_stall", 32'(stalls), 32'd2);
    check_val("post_rst_no_wb", 32'(wb_count), 32'd2);
    check_val("post_rst_miss_data", rdata, 32'hE000_0000);

    // Spurious ack while idle must not disturb state or contents
    @(negedge clk_i);
    spur_req++;
    repeat (3) @(negedge clk_i);
    access(1'b0, 32'h0000_0040, 32'd0, stalls, rdata);
    check_val("spur_stall", 32'(stalls), 32'd0);
    check_val("spur_data40", rdata, 32'hD000_0000);
    access(1'b0, 32'h0000_0204, 32'd0, stalls, rdata);
    check_val("spur_data204", rdata, 32'hE000_0001);
    check_val("spur_rd_cnt", 32'(rd_count), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
